// File: rtl/out_sram_checker.sv
// Streaming result checker: walks an Output SRAM word range and compares each word's low bits to a golden stream within +/-TOL.
// Optional mismatch log FIFO (ports log_pop_i/log_valid_o/log_data_o) enabled by defining ERR_LOG_EN.
module out_sram_checker #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned WORD_W     = 16,
    parameter int unsigned BANK_WORDS = 32768,
    parameter int unsigned NUM_BANKS  = 6,
    parameter int unsigned TOL        = 1,
    parameter int unsigned CNT_W      = 20
`ifdef ERR_LOG_EN
    ,
    parameter int unsigned LOG_DEPTH  = 8
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_i,
    input  logic [CNT_W-1:0]              word_begin_i,
    input  logic [CNT_W-1:0]              word_end_i,
    output logic [NUM_BANKS-1:0]          mem_cs_o,
    output logic [$clog2(BANK_WORDS)-1:0] mem_addr_o,
    input  logic [NUM_BANKS*WORD_W-1:0]   mem_rdata_i,
    input  logic                          gold_valid_i,
    input  logic [DATA_W-1:0]             gold_data_i,
    output logic                          gold_ready_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          pass_o,
    output logic [CNT_W-1:0]              err_cnt_o,
    output logic [CNT_W-1:0]              chk_cnt_o,
    output logic [CNT_W-1:0]              first_err_o
`ifdef ERR_LOG_EN
    ,
    input  logic                          log_pop_i,
    output logic                          log_valid_o,
    output logic [CNT_W+2*DATA_W-1:0]     log_data_o
`endif
);

    localparam int unsigned LA_W   = $clog2(BANK_WORDS);
    localparam int unsigned BK_W   = CNT_W - LA_W;
    localparam int unsigned DIFF_W = DATA_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  idx_q, idx_d, end_q, end_d, cmp_idx_q, cmp_idx_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d, chk_cnt_q, chk_cnt_d, first_err_q, first_err_d;
    logic              rd_v_q, rd_v_d, hold_v_q, hold_v_d;
    logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [BK_W-1:0]   bank_q, bank_d;
    logic [DATA_W-1:0] hold_q, hold_d;

    logic              issue_c, fire_c, mismatch_c, last_c, start_c;
    logic [BK_W-1:0]   issue_bank_c;
    logic [WORD_W-1:0] rd_word_c;
    logic [DATA_W-1:0] cmp_data_c;
    logic [DIFF_W-1:0] diff_c, abs_c;
    logic              unused_c;

    assign issue_bank_c = idx_q[CNT_W-1:LA_W];
    assign start_c      = (state_q == S_IDLE) && start_i;
    // A new read may issue only if its returning data cannot collide with an occupied hold slot.
    assign issue_c      = (state_q == S_RUN) && (idx_q < end_q) && !hold_v_q
                          && (!rd_v_q || gold_valid_i);
    assign fire_c       = (state_q == S_RUN) && (hold_v_q || rd_v_q) && gold_valid_i;
    assign last_c       = (cmp_idx_q == end_q - CNT_W'(1));

    // Return-data mux follows the bank registered alongside the read.
    always_comb begin
        rd_word_c = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            if (bank_q == BK_W'(b)) rd_word_c = mem_rdata_i[b*WORD_W +: WORD_W];
        end
    end
    assign unused_c = ^rd_word_c[WORD_W-1:DATA_W];

    assign cmp_data_c = hold_v_q ? hold_q : rd_word_c[DATA_W-1:0];
    assign diff_c     = {cmp_data_c[DATA_W-1], cmp_data_c} - {gold_data_i[DATA_W-1], gold_data_i};
    assign abs_c      = diff_c[DIFF_W-1] ? (~diff_c + DIFF_W'(1)) : diff_c;
    assign mismatch_c = (abs_c > DIFF_W'(TOL));

    always_comb begin
        mem_cs_o = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            mem_cs_o[b] = issue_c && (issue_bank_c == BK_W'(b));
        end
    end
    assign mem_addr_o   = idx_q[LA_W-1:0];
    assign gold_ready_o = fire_c;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign pass_o       = pass_q;
    assign err_cnt_o    = err_cnt_q;
    assign chk_cnt_o    = chk_cnt_q;
    assign first_err_o  = first_err_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        end_d       = end_q;
        cmp_idx_d   = cmp_idx_q;
        err_cnt_d   = err_cnt_q;
        chk_cnt_d   = chk_cnt_q;
        first_err_d = first_err_q;
        hold_v_d    = hold_v_q;
        hold_d      = hold_q;
        pass_d      = pass_q;
        done_d      = 1'b0;
        rd_v_d      = issue_c;
        bank_d      = issue_c ? issue_bank_c : bank_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    idx_d       = word_begin_i;
                    cmp_idx_d   = word_begin_i;
                    end_d       = word_end_i;
                    err_cnt_d   = '0;
                    chk_cnt_d   = '0;
                    first_err_d = '0;
                    hold_v_d    = 1'b0;
                    pass_d      = 1'b0;
                    if (word_end_i <= word_begin_i) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (issue_c) idx_d = idx_q + CNT_W'(1);
                if (fire_c && hold_v_q) begin
                    hold_v_d = 1'b0;
                end else if (rd_v_q && !gold_valid_i) begin
                    hold_v_d = 1'b1;
                    hold_d   = rd_word_c[DATA_W-1:0];
                end
                if (fire_c) begin
                    chk_cnt_d = chk_cnt_q + CNT_W'(1);
                    cmp_idx_d = cmp_idx_q + CNT_W'(1);
                    if (mismatch_c) begin
                        if (err_cnt_q == '0) first_err_d = cmp_idx_q;
                        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
                    end
                    if (last_c) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                        pass_d  = (err_cnt_d == '0);
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            end_q       <= '0;
            cmp_idx_q   <= '0;
            err_cnt_q   <= '0;
            chk_cnt_q   <= '0;
            first_err_q <= '0;
            rd_v_q      <= 1'b0;
            hold_v_q    <= 1'b0;
            hold_q      <= '0;
            bank_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            end_q       <= end_d;
            cmp_idx_q   <= cmp_idx_d;
            err_cnt_q   <= err_cnt_d;
            chk_cnt_q   <= chk_cnt_d;
            first_err_q <= first_err_d;
            rd_v_q      <= rd_v_d;
            hold_v_q    <= hold_v_d;
            hold_q      <= hold_d;
            bank_q      <= bank_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

`ifdef ERR_LOG_EN
    localparam int unsigned LOG_W = CNT_W + 2*DATA_W;
    localparam int unsigned LP_W  = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;
    localparam int unsigned LC_W  = $clog2(LOG_DEPTH + 1);

    logic [LOG_W-1:0] log_mem_q [LOG_DEPTH];
    logic [LP_W-1:0]  log_wp_q, log_wp_d, log_rp_q, log_rp_d;
    logic [LC_W-1:0]  log_cnt_q, log_cnt_d;
    logic             log_push_c, log_pop_c;

    // Entries arriving while full are dropped; the error counter is unaffected.
    assign log_push_c  = fire_c && mismatch_c && (log_cnt_q != LC_W'(LOG_DEPTH));
    assign log_pop_c   = log_pop_i && (log_cnt_q != '0);
    assign log_valid_o = (log_cnt_q != '0);
    assign log_data_o  = log_mem_q[log_rp_q];

    always_comb begin
        log_wp_d  = log_wp_q;
        log_rp_d  = log_rp_q;
        log_cnt_d = log_cnt_q;
        if (start_c) begin
            log_wp_d  = '0;
            log_rp_d  = '0;
            log_cnt_d = '0;
        end else begin
            if (log_push_c)
                log_wp_d = (log_wp_q == LP_W'(LOG_DEPTH-1)) ? '0 : log_wp_q + LP_W'(1);
            if (log_pop_c)
                log_rp_d = (log_rp_q == LP_W'(LOG_DEPTH-1)) ? '0 : log_rp_q + LP_W'(1);
            if (log_push_c && !log_pop_c)      log_cnt_d = log_cnt_q + LC_W'(1);
            else if (!log_push_c && log_pop_c) log_cnt_d = log_cnt_q - LC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            log_wp_q  <= '0;
            log_rp_q  <= '0;
            log_cnt_q <= '0;
        end else begin
            log_wp_q  <= log_wp_d;
            log_rp_q  <= log_rp_d;
            log_cnt_q <= log_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (log_push_c) log_mem_q[log_wp_q] <= {cmp_idx_q, cmp_data_c, gold_data_i};
    end
`endif

endmodule

// File: tb/tb_out_sram_checker.sv
// Directed self-checking bench for out_sram_checker; a TOL=0 twin shares the stimulus.
module tb_out_sram_checker;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned BW     = 32768;
    localparam int unsigned NB     = 6;
    localparam int unsigned CNT_W  = 20;
    localparam int unsigned LA_W   = 15;
    localparam int unsigned LOG_W  = CNT_W + 2*DATA_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst, start_i, gold_valid_i;
    logic [CNT_W-1:0]     word_begin_i, word_end_i;
    logic [DATA_W-1:0]    gold_data_i;

    logic [NB-1:0]        cs_a, cs_b;
    logic [LA_W-1:0]      addr_a, addr_b;
    logic [NB*WORD_W-1:0] rdata_a, rdata_b;
    logic                 gready_a, gready_b, busy_a, busy_b, done_a, done_b, pass_a, pass_b;
    logic [CNT_W-1:0]     err_a, err_b, chk_a, chk_b, first_a, first_b;
`ifdef ERR_LOG_EN
    logic                 log_pop;
    logic                 lvalid_a, lvalid_b;
    logic [LOG_W-1:0]     ldata_a, ldata_b;
`endif

    int n_pass, n_total, mode;
    int done_cyc, ready_cnt;
    logic [NB-1:0]   cs_log   [0:9];
    logic [LA_W-1:0] addr_log [0:9];

    out_sram_checker #(.TOL(1)) dut (
        .clk(clk), .rst(rst), .start_i(start_i),
        .word_begin_i(word_begin_i), .word_end_i(word_end_i),
        .mem_cs_o(cs_a), .mem_addr_o(addr_a), .mem_rdata_i(rdata_a),
        .gold_valid_i(gold_valid_i), .gold_data_i(gold_data_i), .gold_ready_o(gready_a),
        .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a),
        .err_cnt_o(err_a), .chk_cnt_o(chk_a), .first_err_o(first_a)
`ifdef ERR_LOG_EN
        , .log_pop_i(log_pop), .log_valid_o(lvalid_a), .log_data_o(ldata_a)
`endif
    );

    out_sram_checker #(.TOL(0)) dut0 (
        .clk(clk), .rst(rst), .start_i(start_i),
        .word_begin_i(word_begin_i), .word_end_i(word_end_i),
        .mem_cs_o(cs_b), .mem_addr_o(addr_b), .mem_rdata_i(rdata_b),
        .gold_valid_i(gold_valid_i), .gold_data_i(gold_data_i), .gold_ready_o(gready_b),
        .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b),
        .err_cnt_o(err_b), .chk_cnt_o(chk_b), .first_err_o(first_b)
`ifdef ERR_LOG_EN
        , .log_pop_i(log_pop), .log_valid_o(lvalid_b), .log_data_o(ldata_b)
`endif
    );

    function automatic logic [7:0] base_v(input int idx);
        return 8'((idx * 37 + 60) % 256);
    endfunction

    function automatic logic [7:0] out_v(input int idx);
        if (mode == 1 && (idx == 5 || idx == 9)) return 8'h10;
        if (mode == 2 && (idx == 3 || idx == 7)) return 8'h7F;
        if (mode == 2 && (idx == 4 || idx == 6)) return 8'h80;
        return base_v(idx);
    endfunction

    function automatic logic [7:0] gold_v(input int idx);
        if (mode == 1 && idx == 5) return 8'h11;
        if (mode == 1 && idx == 9) return 8'h13;
        if (mode == 2) begin
            case (idx)
                3: return 8'h80;
                4: return 8'h7F;
                6: return 8'h81;
                7: return 8'h7E;
                default: return base_v(idx);
            endcase
        end
        if (mode == 3) return base_v(idx) + 8'd2;
        return base_v(idx);
    endfunction

    // Banked SRAM models, 1-cycle read latency, upper byte is filler.
    always @(posedge clk) begin
        for (int b = 0; b < int'(NB); b++) begin
            if (cs_a[b]) rdata_a[b*WORD_W +: WORD_W] <= {8'hA5, out_v(b*int'(BW) + int'(addr_a))};
            if (cs_b[b]) rdata_b[b*WORD_W +: WORD_W] <= {8'hA5, out_v(b*int'(BW) + int'(addr_b))};
        end
    end

    // Launch a check and feed gold bytes until done_o (interval 1 = first cycle after the start edge).
    task automatic run_check(input int b, input int e, input bit throttle, input int maxc);
        int   gptr;
        logic rdy;
        gptr      = 0;
        done_cyc  = -1;
        ready_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cs_log[i]   = '0;
            addr_log[i] = '0;
        end
        @(negedge clk);
        word_begin_i = CNT_W'(b);
        word_end_i   = CNT_W'(e);
        start_i      = 1'b1;
        gold_valid_i = 1'b0;
        @(posedge clk);
        #1 start_i = 1'b0;
        for (int c = 1; c <= maxc; c++) begin
            @(negedge clk);
            gold_valid_i = throttle ? (((c-1) % 4 == 0) || ((c-1) % 4 == 3)) : 1'b1;
            gold_data_i  = gold_v(b + gptr);
            #1;
            rdy = gready_a;
            if (rdy) ready_cnt++;
            if (c < 10) begin
                cs_log[c]   = cs_a;
                addr_log[c] = addr_a;
            end
            if (done_a) begin
                done_cyc = c;
                break;
            end
            @(posedge clk);
            if (rdy) gptr++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        gold_valid_i = 1'b1;
        #1;
        n_total++; if ({busy_a, done_a, pass_a} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {busy_a, done_a, pass_a}); else n_pass++;
        n_total++; if (err_a !== '0 || chk_a !== '0 || first_a !== '0) $display("FAIL reset_counters: got err=%0d chk=%0d first=%0d expected 0", err_a, chk_a, first_a); else n_pass++;
        n_total++; if (cs_a !== '0 || gready_a !== 1'b0) $display("FAIL reset_mem_if: got cs=%b ready=%b expected 0", cs_a, gready_a); else n_pass++;
        rst = 1'b0;
        gold_valid_i = 1'b0;
    endtask

    task automatic test_all_match();
        mode = 0;
        run_check(0, 16, 1'b0, 60);
        n_total++; if (done_cyc !== 18) $display("FAIL match_done_cycle: got %0d expected 18", done_cyc); else n_pass++;
        n_total++; if (pass_a !== 1'b1) $display("FAIL match_pass: got %b expected 1", pass_a); else n_pass++;
        n_total++; if (chk_a !== 20'd16) $display("FAIL match_chk: got %0d expected 16", chk_a); else n_pass++;
        n_total++; if (err_a !== 20'd0 || first_a !== 20'd0) $display("FAIL match_err: got err=%0d first=%0d expected 0/0", err_a, first_a); else n_pass++;
        n_total++; if (ready_cnt !== 16) $display("FAIL match_ready_cnt: got %0d expected 16", ready_cnt); else n_pass++;
        @(negedge clk); #1;
        n_total++; if ({done_a, busy_a, pass_a} !== 3'b001) $display("FAIL match_after_done: got done,busy,pass=%b expected 001", {done_a, busy_a, pass_a}); else n_pass++;
    endtask

    task automatic test_mismatch();
        mode = 1;
        run_check(0, 16, 1'b0, 60);
        n_total++; if (done_cyc !== 18) $display("FAIL mism_done_cycle: got %0d expected 18", done_cyc); else n_pass++;
        n_total++; if (err_a !== 20'd1 || first_a !== 20'd9) $display("FAIL mism_tol1: got err=%0d first=%0d expected 1/9", err_a, first_a); else n_pass++;
        n_total++; if (pass_a !== 1'b0) $display("FAIL mism_pass_tol1: got %b expected 0", pass_a); else n_pass++;
        n_total++; if (err_b !== 20'd2 || first_b !== 20'd5) $display("FAIL mism_tol0: got err=%0d first=%0d expected 2/5", err_b, first_b); else n_pass++;
        n_total++; if (chk_b !== 20'd16 || pass_b !== 1'b0) $display("FAIL mism_tol0_chk: got chk=%0d pass=%b expected 16/0", chk_b, pass_b); else n_pass++;
    endtask

    task automatic test_sign_boundary();
        mode = 2;
        run_check(0, 10, 1'b0, 60);
        n_total++; if (done_cyc !== 12) $display("FAIL sign_done_cycle: got %0d expected 12", done_cyc); else n_pass++;
        n_total++; if (err_a !== 20'd2 || first_a !== 20'd3) $display("FAIL sign_tol1: got err=%0d first=%0d expected 2/3", err_a, first_a); else n_pass++;
        n_total++; if (err_b !== 20'd4 || first_b !== 20'd3) $display("FAIL sign_tol0: got err=%0d first=%0d expected 4/3", err_b, first_b); else n_pass++;
    endtask

    task automatic test_bank_cross();
        logic [NB-1:0]   exp_cs   [1:5];
        logic [LA_W-1:0] exp_addr [1:4];
        exp_cs   = '{6'b000001, 6'b000001, 6'b000010, 6'b000010, 6'b000000};
        exp_addr = '{15'd32766, 15'd32767, 15'd0, 15'd1};
        mode = 0;
        run_check(32766, 32770, 1'b0, 30);
        for (int c = 1; c <= 5; c++) begin
            n_total++; if (cs_log[c] !== exp_cs[c]) $display("FAIL bank_cs_c%0d: got %b expected %b", c, cs_log[c], exp_cs[c]); else n_pass++;
        end
        for (int c = 1; c <= 4; c++) begin
            n_total++; if (addr_log[c] !== exp_addr[c]) $display("FAIL bank_addr_c%0d: got %0d expected %0d", c, addr_log[c], exp_addr[c]); else n_pass++;
        end
        n_total++; if (chk_a !== 20'd4 || err_a !== 20'd0 || done_cyc !== 6) $display("FAIL bank_result: got chk=%0d err=%0d done=%0d expected 4/0/6", chk_a, err_a, done_cyc); else n_pass++;
    endtask

    task automatic test_throttle();
        mode = 0;
        run_check(0, 16, 1'b1, 200);
        n_total++; if (done_cyc < 0) $display("FAIL thr_done: got timeout expected done_o"); else n_pass++;
        n_total++; if (ready_cnt !== 16) $display("FAIL thr_ready_cnt: got %0d expected 16", ready_cnt); else n_pass++;
        n_total++; if (chk_a !== 20'd16 || err_a !== 20'd0) $display("FAIL thr_counts: got chk=%0d err=%0d expected 16/0", chk_a, err_a); else n_pass++;
        n_total++; if (pass_a !== 1'b1) $display("FAIL thr_pass: got %b expected 1", pass_a); else n_pass++;
    endtask

    task automatic test_empty();
        mode = 1;
        run_check(7, 7, 1'b0, 10);
        n_total++; if (done_cyc !== 1) $display("FAIL empty_done_cycle: got %0d expected 1", done_cyc); else n_pass++;
        n_total++; if (pass_a !== 1'b1 || chk_a !== 20'd0) $display("FAIL empty_result: got pass=%b chk=%0d expected 1/0", pass_a, chk_a); else n_pass++;
        n_total++; if (err_a !== 20'd0 || ready_cnt !== 0) $display("FAIL empty_cleared: got err=%0d ready=%0d expected 0/0", err_a, ready_cnt); else n_pass++;
    endtask

    task automatic test_mid_reset();
        int   gptr;
        int   done_seen;
        logic rdy;
        mode = 1;
        gptr = 0;
        done_seen = 0;
        @(negedge clk);
        word_begin_i = '0;
        word_end_i   = 20'd16;
        start_i      = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            gold_valid_i = 1'b1;
            gold_data_i  = gold_v(gptr);
            #1 rdy = gready_a;
            @(posedge clk);
            if (rdy) gptr++;
        end
        @(negedge clk);
        gold_data_i = gold_v(gptr);
        #1;
        n_total++; if (err_a !== 20'd1 || chk_a !== 20'd10 || busy_a !== 1'b1) $display("FAIL midrst_pre: got err=%0d chk=%0d busy=%b expected 1/10/1", err_a, chk_a, busy_a); else n_pass++;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        n_total++; if (err_a !== '0 || chk_a !== '0 || first_a !== '0) $display("FAIL midrst_counters: got err=%0d chk=%0d first=%0d expected 0", err_a, chk_a, first_a); else n_pass++;
        n_total++; if ({busy_a, done_a, pass_a, gready_a} !== 4'b0000 || cs_a !== '0) $display("FAIL midrst_flags: got busy,done,pass,ready=%b cs=%b expected 0", {busy_a, done_a, pass_a, gready_a}, cs_a); else n_pass++;
        rst = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            #1 if (done_a || busy_a) done_seen++;
        end
        n_total++; if (done_seen !== 0) $display("FAIL midrst_no_done: got %0d active cycles expected 0", done_seen); else n_pass++;
        gold_valid_i = 1'b0;
    endtask

`ifdef ERR_LOG_EN
    task automatic test_err_log();
        logic [LOG_W-1:0] exp_e;
        mode = 3;
        run_check(0, 10, 1'b0, 60);
        n_total++; if (err_a !== 20'd10) $display("FAIL log_err_cnt: got %0d expected 10", err_a); else n_pass++;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exp_e = {CNT_W'(k), out_v(k), gold_v(k)};
            #1;
            n_total++; if (lvalid_a !== 1'b1 || ldata_a !== exp_e) $display("FAIL log_entry%0d: got v=%b data=%h expected 1/%h", k, lvalid_a, ldata_a, exp_e); else n_pass++;
            log_pop = 1'b1;
            @(posedge clk);
            #1 log_pop = 1'b0;
        end
        @(negedge clk); #1;
        n_total++; if (lvalid_a !== 1'b0) $display("FAIL log_empty: got %b expected 0", lvalid_a); else n_pass++;
    endtask
`endif

    initial begin
        n_pass       = 0;
        n_total      = 0;
        mode         = 0;
        rst          = 1'b1;
        start_i      = 1'b0;
        word_begin_i = '0;
        word_end_i   = '0;
        gold_valid_i = 1'b0;
        gold_data_i  = '0;
        rdata_a      = '0;
        rdata_b      = '0;
`ifdef ERR_LOG_EN
        log_pop      = 1'b0;
`endif
        test_reset();
        test_all_match();
        test_mismatch();
        test_sign_boundary();
        test_bank_cross();
        test_throttle();
        test_empty();
        test_mid_reset();
`ifdef ERR_LOG_EN
        test_err_log();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
